// File: rtl/coprocessor_pkg.sv
// Shared types, defaults and bus-packing helpers for the coprocessor memory subsystem.
`ifndef CP_SLICE
`define CP_SLICE(bus, k, w) bus[int'(k)*(w) +: (w)]
`endif
`ifndef CP_FLAT_WIDTH
`define CP_FLAT_WIDTH(n, w) ((n)*(w))
`endif

package coprocessor_pkg;

   localparam int DEFAULT_NUMBER_OF_REQUESTERS = 4;
   localparam int DEFAULT_WORD_SIZE            = 32;
   localparam int DEFAULT_ADDRESS_WIDTH        = 10;
   localparam int DEFAULT_MAX_HOLD             = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_OWNED    = 2'd1,
      ST_HANDOVER = 2'd2
   } arb_state_e;

   // Index width that stays legal for a single requester.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin pick: first set request bit at or after the pointer, as one-hot and index.
module rr_priority_picker
   import coprocessor_pkg::*;
#(
   parameter  int N     = DEFAULT_NUMBER_OF_REQUESTERS,
   localparam int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         int k;
         k = int'(ptr_i) + i;
         if (k >= N) k = k - N;
         if (!valid_o && req_i[k]) begin
            valid_o    = 1'b1;
            grant_o[k] = 1'b1;
            idx_o      = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter granting one requester at a time ownership of a single memory port.
module memory_arbiter
   import coprocessor_pkg::*;
#(
   parameter int NUMBER_OF_REQUESTERS = DEFAULT_NUMBER_OF_REQUESTERS,
   parameter int WORD_SIZE            = DEFAULT_WORD_SIZE,
   parameter int ADDRESS_WIDTH        = DEFAULT_ADDRESS_WIDTH,
   parameter int MAX_HOLD             = DEFAULT_MAX_HOLD
) (
   input  logic                                                 clk,
   input  logic                                                 reset,
   input  logic [NUMBER_OF_REQUESTERS-1:0]                      i_Requests,
   input  logic [`CP_FLAT_WIDTH(NUMBER_OF_REQUESTERS, ADDRESS_WIDTH)-1:0] i_Addresses,
   input  logic [`CP_FLAT_WIDTH(NUMBER_OF_REQUESTERS, WORD_SIZE)-1:0]     i_Write_Data,
   input  logic [NUMBER_OF_REQUESTERS-1:0]                      i_Write_Enables,
   input  logic [NUMBER_OF_REQUESTERS-1:0]                      i_Read_Enables,
   output logic [NUMBER_OF_REQUESTERS-1:0]                      o_Grants,
   output logic [ADDRESS_WIDTH-1:0]                             o_Memory_Address,
   output logic [WORD_SIZE-1:0]                                 o_Memory_Write_Data,
   output logic                                                 o_Memory_Write_Enable,
   output logic                                                 o_Memory_Read_Enable,
   output logic [NUMBER_OF_REQUESTERS-1:0]                      o_Read_Valid
);

   localparam int N     = NUMBER_OF_REQUESTERS;
   localparam int IDX_W = idx_width(N);
   localparam int CNT_W = $clog2(MAX_HOLD + 1);

   arb_state_e       state_q,  state_d;
   logic [IDX_W-1:0] owner_q,  owner_d;
   logic [IDX_W-1:0] ptr_q,    ptr_d;
   logic [N-1:0]     grant_q,  grant_d;
   logic [N-1:0]     rvalid_q, rvalid_d;
   logic [CNT_W-1:0] hold_q,   hold_d;

   logic [N-1:0]     pick_onehot;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_valid;

   logic             owner_req;
   logic             others_pending;
   logic             hold_expired;
   logic [IDX_W-1:0] next_ptr;

   rr_priority_picker #(.N(N)) u_picker (
      .req_i   (i_Requests),
      .ptr_i   (ptr_q),
      .grant_o (pick_onehot),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   assign owner_req      = i_Requests[owner_q];
   assign others_pending = |(i_Requests & ~grant_q);
   // Counting the current cycle, the owner has used its full hold budget.
   assign hold_expired   = (hold_q >= CNT_W'(MAX_HOLD - 1));
   assign next_ptr       = (owner_q == IDX_W'(N - 1)) ? '0 : owner_q + 1'b1;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      grant_d = '0;
      hold_d  = hold_q;
      unique case (state_q)
         ST_IDLE, ST_HANDOVER: begin
            if (pick_valid) begin
               state_d = ST_OWNED;
               owner_d = pick_idx;
               grant_d = pick_onehot;
               hold_d  = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_OWNED: begin
            hold_d = (hold_q == CNT_W'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
            if (!owner_req || (hold_expired && others_pending)) begin
               state_d = ST_HANDOVER;
               ptr_d   = next_ptr;
            end else begin
               grant_d = grant_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_Memory_Address      = '0;
      o_Memory_Write_Data   = '0;
      o_Memory_Write_Enable = 1'b0;
      o_Memory_Read_Enable  = 1'b0;
      if (state_q == ST_OWNED) begin
         o_Memory_Address      = `CP_SLICE(i_Addresses, owner_q, ADDRESS_WIDTH);
         o_Memory_Write_Data   = `CP_SLICE(i_Write_Data, owner_q, WORD_SIZE);
         o_Memory_Write_Enable = i_Write_Enables[owner_q];
         // A simultaneous write takes the port; the read is dropped.
         o_Memory_Read_Enable  = i_Read_Enables[owner_q] & ~i_Write_Enables[owner_q];
      end
   end

   assign rvalid_d = o_Memory_Read_Enable ? grant_q : '0;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         owner_q  <= '0;
         ptr_q    <= '0;
         grant_q  <= '0;
         rvalid_q <= '0;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         rvalid_q <= rvalid_d;
         hold_q   <= hold_d;
      end
   end

   assign o_Grants     = grant_q;
   assign o_Read_Valid = rvalid_q;

endmodule
